// File: rtl/mem_stage_pipe.sv
// Pipeline MEM stage: issues aligned loads/stores to a ready-handshake memory, waits with timeout, registers WB.
// Latency: 1 cycle after mem_rdy (0 wait in IDLE), 1 cycle for non-memory/misaligned ops.
// Backpressure: stall_out holds the EX/MEM register while in WAIT or while an IDLE memory op lacks mem_rdy.
module mem_stage_pipe #(
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       alu_out_in,
    input  logic [31:0]       st_data_in,
    input  logic [31:0]       pc_plus4_in,
    input  logic [REG_AW-1:0] reg_dest_in,
    input  logic              reg_wr,
    input  logic              wb_sel,
    input  logic              call,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        size,
    input  logic              ld_signed,
    input  logic              flush,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rdy,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       mem_out_out,
    output logic [31:0]       alu_out_out,
    output logic [31:0]       pc_plus4_out,
    output logic [REG_AW-1:0] reg_dest_out,
    output logic              reg_wr_out,
    output logic              wb_sel_out,
    output logic              call_out,
    output logic              err_out
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    state_t            state;
    logic [7:0]        wait_cnt;

    logic              h_we, h_load, h_sgn, h_regwr, h_wbsel, h_call;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata, h_alu, h_pc;
    logic [3:0]        h_be;
    logic [1:0]        h_size;
    logic [REG_AW-1:0] h_dest;

    logic              mem_op, misaligned, issue, in_wait;
    logic [3:0]        in_be;
    logic [31:0]       in_wdata;

    logic              done, d_err, d_regwr, d_wbsel, d_call;
    logic [31:0]       d_mem_out, d_alu, d_pc;
    logic [REG_AW-1:0] d_dest;

    function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sgn);
        logic [31:0] lane;
        lane = rdata >> {a, 3'b000};
        case (sz)
            2'b00:   load_ext = {{24{sgn & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{sgn & lane[15]}}, lane[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

    assign in_wait = (state == S_WAIT);
    assign mem_op  = in_valid & (mem_rd | mem_wr) & ~flush;

    always_comb begin
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_out_in[0];
            2'b10:   misaligned = (alu_out_in[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        in_be    = 4'b0000;
        in_wdata = st_data_in;
        case (size)
            2'b00: begin
                in_wdata = {4{st_data_in[7:0]}};
                if (mem_wr) in_be = 4'b0001 << alu_out_in[1:0];
            end
            2'b01: begin
                in_wdata = {2{st_data_in[15:0]}};
                if (mem_wr) in_be = 4'b0011 << alu_out_in[1:0];
            end
            default: if (mem_wr) in_be = 4'b1111;
        endcase
    end

    assign issue     = ~in_wait & mem_op & ~misaligned;
    assign mem_req   = ~rst & (issue | in_wait);
    assign mem_we    = in_wait ? h_we    : mem_wr;
    assign mem_addr  = in_wait ? h_addr  : alu_out_in[ADDR_W-1:0];
    assign mem_wdata = in_wait ? h_wdata : in_wdata;
    assign mem_be    = rst ? 4'b0000 : (in_wait ? h_be : (issue ? in_be : 4'b0000));
    assign stall_out = ~rst & (in_wait | (mem_op & ~mem_rdy));

    // Completion decode: the WB payload comes from the live inputs in IDLE and from the holding registers in WAIT.
    always_comb begin
        done      = 1'b0;
        d_err     = 1'b0;
        d_mem_out = 32'h0;
        d_alu     = alu_out_in;
        d_pc      = pc_plus4_in;
        d_dest    = reg_dest_in;
        d_regwr   = reg_wr;
        d_wbsel   = wb_sel;
        d_call    = call;
        if (!in_wait) begin
            if (in_valid && !flush) begin
                if (!(mem_rd || mem_wr)) begin
                    done = 1'b1;
                end else if (misaligned) begin
                    done  = 1'b1;
                    d_err = 1'b1;
                end else if (mem_rdy) begin
                    done = 1'b1;
                    if (mem_rd && !mem_wr)
                        d_mem_out = load_ext(mem_rdata, alu_out_in[1:0], size, ld_signed);
                end
            end
        end else begin
            d_alu   = h_alu;
            d_pc    = h_pc;
            d_dest  = h_dest;
            d_regwr = h_regwr;
            d_wbsel = h_wbsel;
            d_call  = h_call;
            if (mem_rdy) begin
                done = 1'b1;
                if (h_load) d_mem_out = load_ext(mem_rdata, h_addr[1:0], h_size, h_sgn);
            end else if (wait_cnt == MAX_W8) begin
                done  = 1'b1;
                d_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'd0;
            h_we         <= 1'b0;
            h_load       <= 1'b0;
            h_sgn        <= 1'b0;
            h_regwr      <= 1'b0;
            h_wbsel      <= 1'b0;
            h_call       <= 1'b0;
            h_addr       <= '0;
            h_wdata      <= 32'h0;
            h_alu        <= 32'h0;
            h_pc         <= 32'h0;
            h_be         <= 4'b0000;
            h_size       <= 2'b00;
            h_dest       <= '0;
            wb_valid     <= 1'b0;
            mem_out_out  <= 32'h0;
            alu_out_out  <= 32'h0;
            pc_plus4_out <= 32'h0;
            reg_dest_out <= '0;
            reg_wr_out   <= 1'b0;
            wb_sel_out   <= 1'b0;
            call_out     <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue && !mem_rdy) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd0;
                        h_we     <= mem_wr;
                        h_load   <= mem_rd & ~mem_wr;
                        h_sgn    <= ld_signed;
                        h_regwr  <= reg_wr;
                        h_wbsel  <= wb_sel;
                        h_call   <= call;
                        h_addr   <= alu_out_in[ADDR_W-1:0];
                        h_wdata  <= in_wdata;
                        h_alu    <= alu_out_in;
                        h_pc     <= pc_plus4_in;
                        h_be     <= in_be;
                        h_size   <= size;
                        h_dest   <= reg_dest_in;
                    end
                end
                S_WAIT: begin
                    if (mem_rdy || wait_cnt == MAX_W8) state <= S_IDLE;
                    else                               wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= S_IDLE;
            endcase

            wb_valid <= done;
            if (done) begin
                mem_out_out  <= d_mem_out;
                alu_out_out  <= d_alu;
                pc_plus4_out <= d_pc;
                reg_dest_out <= d_dest;
                reg_wr_out   <= d_regwr & ~d_err;
                wb_sel_out   <= d_wbsel;
                call_out     <= d_call;
                err_out      <= d_err;
            end else begin
                mem_out_out  <= 32'h0;
                alu_out_out  <= 32'h0;
                pc_plus4_out <= 32'h0;
                reg_dest_out <= '0;
                reg_wr_out   <= 1'b0;
                wb_sel_out   <= 1'b0;
                call_out     <= 1'b0;
                err_out      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed scenarios plus random ops against a rule-level reference model.
module tb_mem_stage_pipe;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, reg_wr, wb_sel, call, mem_rd, mem_wr, ld_signed, flush;
    logic [31:0] alu_out_in, st_data_in, pc_plus4_in;
    logic [3:0]  reg_dest_in;
    logic [1:0]  size;
    logic        stall_out, mem_req, mem_we, mem_rdy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, reg_wr_out, wb_sel_out, call_out, err_out;
    logic [31:0] mem_out_out, alu_out_out, pc_plus4_out;
    logic [3:0]  reg_dest_out;

    always #5 clk = ~clk;

    mem_stage_pipe #(.ADDR_W(32), .REG_AW(4), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out_in(alu_out_in),
        .st_data_in(st_data_in), .pc_plus4_in(pc_plus4_in), .reg_dest_in(reg_dest_in),
        .reg_wr(reg_wr), .wb_sel(wb_sel), .call(call), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .size(size), .ld_signed(ld_signed), .flush(flush), .stall_out(stall_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .mem_out_out(mem_out_out), .alu_out_out(alu_out_out), .pc_plus4_out(pc_plus4_out),
        .reg_dest_out(reg_dest_out), .reg_wr_out(reg_wr_out), .wb_sel_out(wb_sel_out),
        .call_out(call_out), .err_out(err_out)
    );

    typedef struct packed {
        logic [31:0] alu, st, pc;
        logic [3:0]  dest;
        logic        reg_wr, wb_sel, call, rd, wr;
        logic [1:0]  size;
        logic        sgn;
    } op_t;

    int checks = 0;
    int failures = 0;

    // Observations gathered by drive_op
    int          o_stall, o_req, o_wb, o_wbcyc;
    logic        o_unstable, o_hang, o_we, o_err, o_regwr, o_wbsel, o_call;
    logic [3:0]  o_be, o_dest;
    logic [31:0] o_addr, o_wdata, o_mem_out, o_alu, o_pc;

    // Expectations produced by the model
    int          e_wb, e_stall, e_req, e_wbcyc;
    logic        e_err, e_regwr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_mem_out;

    task automatic set_inputs(input op_t op);
        alu_out_in  = op.alu;
        st_data_in  = op.st;
        pc_plus4_in = op.pc;
        reg_dest_in = op.dest;
        reg_wr      = op.reg_wr;
        wb_sel      = op.wb_sel;
        call        = op.call;
        mem_rd      = op.rd;
        mem_wr      = op.wr;
        size        = op.size;
        ld_signed   = op.sgn;
    endtask

    function automatic op_t mk_op(input logic rd, input logic wr, input logic [1:0] sz,
                                  input logic sgn, input logic [31:0] addr, input logic [31:0] st);
        op_t op;
        op.alu = addr;  op.st = st;  op.pc = $urandom;  op.dest = 4'($urandom);
        op.reg_wr = 1'b1;  op.wb_sel = 1'($urandom);  op.call = 1'($urandom);
        op.rd = rd;  op.wr = wr;  op.size = sz;  op.sgn = sgn;
        return op;
    endfunction

    // Reference model: outcome of one op from the stage's rules.
    // delay = cycle (from presentation) where mem_rdy rises, -1 = never.
    task automatic model(input op_t op, input int delay, input logic [31:0] rdata, input int flush_from);
        logic [1:0]  a;
        logic [31:0] lane;
        bit          memop, mis;
        a     = op.alu[1:0];
        memop = op.rd | op.wr;
        mis   = (op.size == 2'd3) || (op.size == 2'd1 && a[0]) || (op.size == 2'd2 && a != 2'd0);
        e_wb = 0; e_stall = 0; e_req = 0; e_wbcyc = -1; e_err = 0;
        e_mem_out = 0; e_be = 0; e_wdata = 0;
        if (flush_from == 0) begin
        end else if (!memop) begin
            e_wb = 1; e_wbcyc = 0;
        end else if (mis) begin
            e_wb = 1; e_wbcyc = 0; e_err = 1; e_stall = (delay == 0) ? 0 : 1;
        end else begin
            e_wb = 1;
            if (op.wr) begin
                if (op.size == 0)      begin e_be = 4'(1 << a); e_wdata = {4{op.st[7:0]}};  end
                else if (op.size == 1) begin e_be = 4'(3 << a); e_wdata = {2{op.st[15:0]}}; end
                else                   begin e_be = 4'hF;      e_wdata = op.st;            end
            end
            if (delay >= 0 && delay <= MW + 1) begin
                e_stall = (delay == 0) ? 0 : delay + 1;
                e_req   = delay + 1;
                e_wbcyc = delay;
                if (!op.wr) begin
                    lane = rdata >> (8 * a);
                    if (op.size == 0) begin
                        e_mem_out = lane & 32'hFF;
                        if (op.sgn && lane[7]) e_mem_out = e_mem_out + 32'hFFFF_FF00;
                    end else if (op.size == 1) begin
                        e_mem_out = lane & 32'hFFFF;
                        if (op.sgn && lane[15]) e_mem_out = e_mem_out + 32'hFFFF_0000;
                    end else begin
                        e_mem_out = rdata;
                    end
                end
            end else begin
                e_stall = MW + 2; e_req = MW + 2; e_wbcyc = MW + 1; e_err = 1;
            end
        end
        e_regwr = op.reg_wr & ~e_err;
    endtask

    // Presents op, holds it until consumed (stall low at an edge, or a completion), then idles 3 cycles.
    task automatic drive_op(input op_t op, input int delay, input logic [31:0] rdata, input int flush_from);
        bit   consumed;
        int   post;
        logic st;
        o_stall = 0; o_req = 0; o_wb = 0; o_wbcyc = -1; o_unstable = 0;
        o_be = 0; o_addr = 0; o_wdata = 0; o_we = 0;
        o_err = 0; o_regwr = 0; o_wbsel = 0; o_call = 0; o_dest = 0;
        o_mem_out = 0; o_alu = 0; o_pc = 0;
        @(negedge clk);
        set_inputs(op);
        mem_rdata = rdata;
        in_valid  = 1'b1;
        consumed  = 0;
        post      = 0;
        for (int cyc = 0; cyc < 400 && post < 3; cyc++) begin
            if (!consumed) begin
                mem_rdy = (delay >= 0 && cyc >= delay);
                flush   = (flush_from >= 0 && cyc >= flush_from);
            end else begin
                mem_rdy = 1'b0; flush = 1'b0; in_valid = 1'b0;
            end
            #1;
            st = stall_out;
            if (stall_out) o_stall++;
            if (mem_req) begin
                if (o_req == 0) begin
                    o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
                end else if (o_be !== mem_be || o_addr !== mem_addr || o_wdata !== mem_wdata || o_we !== mem_we) begin
                    o_unstable = 1;
                end
                o_req++;
            end
            @(posedge clk);
            #1;
            if (wb_valid) begin
                o_wb++;
                if (o_wbcyc < 0) begin
                    o_wbcyc = cyc; o_mem_out = mem_out_out; o_alu = alu_out_out; o_pc = pc_plus4_out;
                    o_dest = reg_dest_out; o_regwr = reg_wr_out; o_wbsel = wb_sel_out;
                    o_call = call_out; o_err = err_out;
                end
            end
            if (consumed) post++;
            else if (!st || wb_valid) consumed = 1;
            @(negedge clk);
        end
        o_hang = !consumed;
        in_valid = 1'b0; mem_rdy = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_inputs(mk_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678));
        in_valid = 1'b1; mem_rdy = 1'b0; flush = 1'b0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_out); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", mem_req); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_be got=%h want=0", mem_be); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
        checks++; if ({mem_out_out, alu_out_out, pc_plus4_out, reg_dest_out, reg_wr_out, err_out, wb_sel_out, call_out} !== '0) begin
            failures++; $display("FAIL reset_wb_fields got=%h/%h/%h want=0", mem_out_out, alu_out_out, pc_plus4_out);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_zero_wait_lb;
        drive_op(mk_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0), 0, 32'h80FF_FF00, -1);
        checks++; if (o_stall !== 0) begin failures++; $display("FAIL lb_stall got=%0d want=0", o_stall); end
        checks++; if (o_req !== 1 || o_be !== 4'h0 || o_addr !== 32'h1003 || o_we !== 1'b0) begin
            failures++; $display("FAIL lb_request req=%0d be=%h addr=%h we=%b want 1/0/1003/0", o_req, o_be, o_addr, o_we);
        end
        checks++; if (o_wb !== 1 || o_wbcyc !== 0) begin failures++; $display("FAIL lb_wb count=%0d cyc=%0d want 1/0", o_wb, o_wbcyc); end
        checks++; if (o_mem_out !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h want=ffffff80", o_mem_out); end
    endtask

    task automatic test_store_wait;
        drive_op(mk_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h2000, 32'hDEAD_BEEF), 3, 32'h0, -1);
        checks++; if (o_stall !== 4) begin failures++; $display("FAIL sw_stall got=%0d want=4", o_stall); end
        checks++; if (o_be !== 4'hF || o_unstable !== 1'b0 || o_we !== 1'b1) begin
            failures++; $display("FAIL sw_be be=%h unstable=%b we=%b want f/0/1", o_be, o_unstable, o_we);
        end
        checks++; if (o_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h want=deadbeef", o_wdata); end
        checks++; if (o_wb !== 1 || o_wbcyc !== 3) begin failures++; $display("FAIL sw_wb count=%0d cyc=%0d want 1/3", o_wb, o_wbcyc); end
        checks++; if (o_mem_out !== 32'h0 || o_err !== 1'b0) begin failures++; $display("FAIL sw_out data=%h err=%b want 0/0", o_mem_out, o_err); end
    endtask

    task automatic test_timeout;
        drive_op(mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0), -1, 32'h5555_AAAA, -1);
        checks++; if (o_hang !== 1'b0) begin failures++; $display("FAIL to_hang got=%b want=0", o_hang); end
        checks++; if (o_req !== MW + 2 || o_stall !== MW + 2) begin
            failures++; $display("FAIL to_length req=%0d stall=%0d want %0d", o_req, o_stall, MW + 2);
        end
        checks++; if (o_wb !== 1 || o_wbcyc !== MW + 1) begin failures++; $display("FAIL to_wb count=%0d cyc=%0d want 1/%0d", o_wb, o_wbcyc, MW + 1); end
        checks++; if (o_err !== 1'b1 || o_regwr !== 1'b0 || o_mem_out !== 32'h0) begin
            failures++; $display("FAIL to_err err=%b reg_wr=%b data=%h want 1/0/0", o_err, o_regwr, o_mem_out);
        end
    endtask

    task automatic test_misaligned;
        drive_op(mk_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h3001, 32'h0), -1, 32'h0, -1);
        checks++; if (o_req !== 0) begin failures++; $display("FAIL lh_mis_req got=%0d want=0", o_req); end
        checks++; if (o_wb !== 1 || o_wbcyc !== 0 || o_err !== 1'b1 || o_regwr !== 1'b0) begin
            failures++; $display("FAIL lh_mis_wb count=%0d cyc=%0d err=%b reg_wr=%b want 1/0/1/0", o_wb, o_wbcyc, o_err, o_regwr);
        end
    endtask

    task automatic test_flush;
        drive_op(mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0), 0, 32'h1111_2222, 0);
        checks++; if (o_req !== 0 || o_wb !== 0) begin failures++; $display("FAIL flush_idle req=%0d wb=%0d want 0/0", o_req, o_wb); end
        drive_op(mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h504, 32'h0), 5, 32'h3333_4444, 1);
        checks++; if (o_wb !== 1 || o_err !== 1'b0 || o_mem_out !== 32'h3333_4444 || o_wbcyc !== 5) begin
            failures++; $display("FAIL flush_wait wb=%0d err=%b data=%h cyc=%0d want 1/0/33334444/5", o_wb, o_err, o_mem_out, o_wbcyc);
        end
    endtask

    task automatic test_reset_in_wait;
        int wb_seen;
        int bad;
        @(negedge clk);
        set_inputs(mk_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0));
        in_valid = 1'b1; mem_rdy = 1'b0; mem_rdata = 32'h7777_7777;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall_out !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL rstw_pre stall=%b req=%b want 1/1", stall_out, mem_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; mem_rdy = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL rstw_idle stall=%b req=%b wb=%b want 0/0/0", stall_out, mem_req, wb_valid);
        end
        wb_seen = 0; bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (wb_valid) wb_seen++;
            if (stall_out || mem_req) bad++;
        end
        checks++; if (wb_seen !== 0 || bad !== 0) begin failures++; $display("FAIL rstw_abandon wb=%0d busy=%0d want 0/0", wb_seen, bad); end
        @(negedge clk); mem_rdy = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_alu, exp_mem;
        bit          is_ld;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            is_ld = (i % 2 == 1);
            exp_alu = is_ld ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            exp_mem = $urandom;
            set_inputs(mk_op(is_ld, 1'b0, 2'd2, 1'b0, exp_alu, 32'h0));
            in_valid = 1'b1; mem_rdy = 1'b1; mem_rdata = exp_mem; flush = 1'b0;
            @(posedge clk); #1;
            checks++; if (wb_valid !== 1'b1 || alu_out_out !== exp_alu || mem_out_out !== (is_ld ? exp_mem : 32'h0)) begin
                failures++; $display("FAIL b2b_%0d wb=%b alu=%h data=%h want 1/%h/%h", i, wb_valid, alu_out_out, mem_out_out, exp_alu, is_ld ? exp_mem : 32'h0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; mem_rdy = 1'b0;
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain wb=%b want 0", wb_valid); end
    endtask

    task automatic test_random;
        op_t         op;
        int          kind, delay, ff, r;
        logic [31:0] rdata;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            op = mk_op(kind >= 2 && kind <= 5, kind >= 6, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 9) == 0) op.size = 2'd3;
            if ($urandom_range(0, 1) == 0) op.alu[1:0] = 2'b00;
            r = $urandom_range(0, 19);
            delay = (r < 8) ? 0 : (r < 17) ? $urandom_range(1, 5) : (r == 17) ? MW + 1 : -1;
            r = $urandom_range(0, 9);
            ff = (r == 0) ? 0 : (r == 1) ? 1 : -1;
            rdata = $urandom;
            model(op, delay, rdata, ff);
            drive_op(op, delay, rdata, ff);
            checks++; if (o_hang !== 1'b0 || o_wb !== e_wb || o_wbcyc !== e_wbcyc) begin
                failures++; $display("FAIL rnd%0d_wb hang=%b count=%0d cyc=%0d want 0/%0d/%0d", n, o_hang, o_wb, o_wbcyc, e_wb, e_wbcyc);
            end
            checks++; if (o_stall !== e_stall || o_req !== e_req) begin
                failures++; $display("FAIL rnd%0d_timing stall=%0d req=%0d want %0d/%0d", n, o_stall, o_req, e_stall, e_req);
            end
            if (e_wb != 0) begin
                checks++; if (o_err !== e_err || o_mem_out !== e_mem_out || o_regwr !== e_regwr) begin
                    failures++; $display("FAIL rnd%0d_result err=%b data=%h reg_wr=%b want %b/%h/%b", n, o_err, o_mem_out, o_regwr, e_err, e_mem_out, e_regwr);
                end
                checks++; if (o_alu !== op.alu || o_pc !== op.pc || o_dest !== op.dest || o_wbsel !== op.wb_sel || o_call !== op.call) begin
                    failures++; $display("FAIL rnd%0d_pass alu=%h pc=%h dest=%h want %h/%h/%h", n, o_alu, o_pc, o_dest, op.alu, op.pc, op.dest);
                end
            end
            if (e_req != 0) begin
                checks++; if (o_be !== e_be || o_addr !== op.alu || o_wdata !== (op.wr ? e_wdata : o_wdata) || o_we !== op.wr || o_unstable !== 1'b0) begin
                    failures++; $display("FAIL rnd%0d_req be=%h addr=%h wdata=%h we=%b unstable=%b want %h/%h/%h/%b/0", n, o_be, o_addr, o_wdata, o_we, o_unstable, e_be, op.alu, e_wdata, op.wr);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; mem_rdy = 1'b0; mem_rdata = 32'h0;
        set_inputs('0);
        test_reset;
        test_zero_wait_lb;
        test_store_wait;
        test_timeout;
        test_misaligned;
        test_flush;
        test_reset_in_wait;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
